// File: rtl/calc_ctrl_if.sv
// Keypad/button inputs and display/status outputs of the calculator controller.
interface calc_ctrl_if #(
   parameter int WIDTH = 16
);
   logic [3:0]       keypad_input;
   logic             read_input;
   logic             sign_input;
   logic [2:0]       operator_input;
   logic             equal_input;
   logic             clear_input;
   logic             complete;
   logic             busy;
   logic             overflow;
   logic [WIDTH-1:0] display_output;

   // Driver side: debouncers feed inputs, display driver consumes outputs.
   modport master (
      output keypad_input, read_input, sign_input, operator_input, equal_input, clear_input,
      input  complete, busy, overflow, display_output
   );

   // Controller side.
   modport slave (
      input  keypad_input, read_input, sign_input, operator_input, equal_input, clear_input,
      output complete, busy, overflow, display_output
   );
endinterface

// File: rtl/calc_ctrl.sv
// Signed integer keypad calculator controller: decimal operand entry with sign,
// add/sub in one cycle, shift-add multiply, overflow flag and result chaining.
module calc_ctrl #(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 5
) (
   input logic        clk,
   input logic        RST,
   calc_ctrl_if.slave bus
);
   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam int IW = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b100;

   typedef enum logic [1:0] {S_ENTRY_A, S_ENTRY_B, S_COMPUTE, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [WIDTH-1:0]        a_mag_q, a_mag_d, b_mag_q, b_mag_d;
   logic                    a_sign_q, a_sign_d, b_sign_q, b_sign_d;
   logic [CW-1:0]           a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
   logic                    b_shown_q, b_shown_d;
   logic [2:0]              op_q, op_d;
   logic signed [WIDTH-1:0] result_q, result_d;
   logic                    ovf_q, ovf_d;
   logic [2*WIDTH-1:0]      acc_q, acc_d, mcand_q, mcand_d;
   logic [WIDTH-1:0]        mplier_q, mplier_d;
   logic [IW-1:0]           iter_q, iter_d;
   logic                    prod_neg_q, prod_neg_d;
   logic                    read_prev_q, read_prev_d, sign_prev_q, sign_prev_d;
   logic                    busy_q, busy_d, complete_q, complete_d;

   // Two's-complement operand value from stored magnitude and sign.
   function automatic logic signed [WIDTH-1:0] to_value(input logic [WIDTH-1:0] mag,
                                                        input logic sgn);
      to_value = sgn ? -$signed(mag) : $signed(mag);
   endfunction

   // Unsigned magnitude of a signed operand (most negative value maps to 2^(WIDTH-1)).
   function automatic logic [WIDTH-1:0] abs_u(input logic signed [WIDTH-1:0] v);
      abs_u = v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
   endfunction

   // Decimal shift-in of one digit, wrapping modulo 2^WIDTH.
   function automatic logic [WIDTH-1:0] shift_digit(input logic [WIDTH-1:0] mag,
                                                    input logic [3:0] dig);
      shift_digit = mag * WIDTH'(10) + WIDTH'(dig);
   endfunction

   logic                      read_rise, sign_rise, digit_ev, op_ok;
   logic signed [WIDTH-1:0]   a_val, b_val, neg_b, sum_val, dif_val;
   logic                      sum_ovf, dif_ovf, prod_ovf;
   logic signed [2*WIDTH-1:0] prod_val;

   assign read_rise = bus.read_input & ~read_prev_q;
   assign sign_rise = bus.sign_input & ~sign_prev_q;
   assign digit_ev  = read_rise && (bus.keypad_input <= 4'd9);
   assign op_ok     = (bus.operator_input == OP_ADD) || (bus.operator_input == OP_SUB) ||
                      (bus.operator_input == OP_MUL);

   assign a_val    = to_value(a_mag_q, a_sign_q);
   assign b_val    = to_value(b_mag_q, b_sign_q);
   assign neg_b    = -b_val;
   assign sum_val  = a_val + b_val;
   assign dif_val  = a_val - b_val;
   assign sum_ovf  = (a_val[WIDTH-1] == b_val[WIDTH-1]) && (sum_val[WIDTH-1] != a_val[WIDTH-1]);
   assign dif_ovf  = (a_val[WIDTH-1] == neg_b[WIDTH-1]) && (dif_val[WIDTH-1] != a_val[WIDTH-1]);
   assign prod_val = prod_neg_q ? -$signed(acc_q) : $signed(acc_q);
   assign prod_ovf = prod_val != {{WIDTH{prod_val[WIDTH-1]}}, prod_val[WIDTH-1:0]};

   // Next-state logic: clear first, then operator over digit, per-state event handling.
   always_comb begin
      state_d     = state_q;
      a_mag_d     = a_mag_q;
      a_sign_d    = a_sign_q;
      a_cnt_d     = a_cnt_q;
      b_mag_d     = b_mag_q;
      b_sign_d    = b_sign_q;
      b_cnt_d     = b_cnt_q;
      b_shown_d   = b_shown_q;
      op_d        = op_q;
      result_d    = result_q;
      ovf_d       = ovf_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      iter_d      = iter_q;
      prod_neg_d  = prod_neg_q;
      read_prev_d = bus.read_input;
      sign_prev_d = bus.sign_input;

      if (bus.clear_input) begin
         state_d    = S_ENTRY_A;
         a_mag_d    = '0;
         a_sign_d   = 1'b0;
         a_cnt_d    = '0;
         b_mag_d    = '0;
         b_sign_d   = 1'b0;
         b_cnt_d    = '0;
         b_shown_d  = 1'b0;
         op_d       = '0;
         result_d   = '0;
         ovf_d      = 1'b0;
         acc_d      = '0;
         mcand_d    = '0;
         mplier_d   = '0;
         iter_d     = '0;
         prod_neg_d = 1'b0;
      end else begin
         unique case (state_q)
            S_ENTRY_A: begin
               if (op_ok) begin
                  op_d      = bus.operator_input;
                  b_mag_d   = '0;
                  b_sign_d  = 1'b0;
                  b_cnt_d   = '0;
                  b_shown_d = 1'b0;
                  state_d   = S_ENTRY_B;
               end else begin
                  if (digit_ev && (a_cnt_q < CW'(MAX_DIGITS))) begin
                     a_mag_d = shift_digit(a_mag_q, bus.keypad_input);
                     a_cnt_d = a_cnt_q + CW'(1);
                  end
                  if (sign_rise) a_sign_d = ~a_sign_q;
               end
            end
            S_ENTRY_B: begin
               if (bus.equal_input) begin
                  acc_d      = '0;
                  mcand_d    = {{WIDTH{1'b0}}, abs_u(a_val)};
                  mplier_d   = abs_u(b_val);
                  iter_d     = '0;
                  prod_neg_d = a_val[WIDTH-1] ^ b_val[WIDTH-1];
                  state_d    = S_COMPUTE;
               end else if (op_ok) begin
                  op_d = bus.operator_input;
               end else begin
                  if (digit_ev) begin
                     b_shown_d = 1'b1;
                     if (b_cnt_q < CW'(MAX_DIGITS)) begin
                        b_mag_d = shift_digit(b_mag_q, bus.keypad_input);
                        b_cnt_d = b_cnt_q + CW'(1);
                     end
                  end
                  if (sign_rise) begin
                     b_shown_d = 1'b1;
                     b_sign_d  = ~b_sign_q;
                  end
               end
            end
            S_COMPUTE: begin
               if (op_q == OP_MUL) begin
                  if (iter_q < IW'(WIDTH)) begin
                     acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
                     mcand_d  = mcand_q << 1;
                     mplier_d = mplier_q >> 1;
                     iter_d   = iter_q + IW'(1);
                  end else begin
                     result_d = prod_val[WIDTH-1:0];
                     ovf_d    = prod_ovf;
                     state_d  = S_DONE;
                  end
               end else if (op_q == OP_SUB) begin
                  result_d = dif_val;
                  ovf_d    = dif_ovf;
                  state_d  = S_DONE;
               end else begin
                  result_d = sum_val;
                  ovf_d    = sum_ovf;
                  state_d  = S_DONE;
               end
            end
            S_DONE: begin
               if (op_ok) begin
                  a_mag_d   = result_q;
                  a_sign_d  = 1'b0;
                  a_cnt_d   = CW'(MAX_DIGITS);
                  op_d      = bus.operator_input;
                  b_mag_d   = '0;
                  b_sign_d  = 1'b0;
                  b_cnt_d   = '0;
                  b_shown_d = 1'b0;
                  state_d   = S_ENTRY_B;
               end else if (digit_ev) begin
                  a_mag_d  = WIDTH'(bus.keypad_input);
                  a_sign_d = 1'b0;
                  a_cnt_d  = CW'(1);
                  state_d  = S_ENTRY_A;
               end
            end
            default: state_d = S_ENTRY_A;
         endcase
      end

      busy_d     = (state_d == S_COMPUTE);
      complete_d = (state_d == S_DONE);
   end

   // State and datapath registers; reset returns every output to zero at once.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q     <= S_ENTRY_A;
         a_mag_q     <= '0;
         a_sign_q    <= 1'b0;
         a_cnt_q     <= '0;
         b_mag_q     <= '0;
         b_sign_q    <= 1'b0;
         b_cnt_q     <= '0;
         b_shown_q   <= 1'b0;
         op_q        <= '0;
         result_q    <= '0;
         ovf_q       <= 1'b0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         iter_q      <= '0;
         prod_neg_q  <= 1'b0;
         read_prev_q <= 1'b0;
         sign_prev_q <= 1'b0;
         busy_q      <= 1'b0;
         complete_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_mag_q     <= a_mag_d;
         a_sign_q    <= a_sign_d;
         a_cnt_q     <= a_cnt_d;
         b_mag_q     <= b_mag_d;
         b_sign_q    <= b_sign_d;
         b_cnt_q     <= b_cnt_d;
         b_shown_q   <= b_shown_d;
         op_q        <= op_d;
         result_q    <= result_d;
         ovf_q       <= ovf_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         iter_q      <= iter_d;
         prod_neg_q  <= prod_neg_d;
         read_prev_q <= read_prev_d;
         sign_prev_q <= sign_prev_d;
         busy_q      <= busy_d;
         complete_q  <= complete_d;
      end
   end

   // Display selects the operand being entered, or the result once done.
   always_comb begin
      bus.display_output = a_val;
      unique case (state_q)
         S_ENTRY_A: bus.display_output = a_val;
         S_ENTRY_B,
         S_COMPUTE: bus.display_output = b_shown_q ? b_val : a_val;
         S_DONE:    bus.display_output = result_q;
         default:   bus.display_output = a_val;
      endcase
   end

   assign bus.busy     = busy_q;
   assign bus.complete = complete_q;
   assign bus.overflow = complete_q & ovf_q;
endmodule

// File: tb/tb_calc_ctrl.sv
// Directed self-checking bench for calc_ctrl at WIDTH=16, MAX_DIGITS=5.
module tb_calc_ctrl;
   logic clk = 1'b0;
   logic RST = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   calc_ctrl_if #(.WIDTH(16)) ifc ();

   calc_ctrl #(.WIDTH(16), .MAX_DIGITS(5)) dut (
      .clk (clk),
      .RST (RST),
      .bus (ifc.slave)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic press_digit(input int d);
      ifc.keypad_input = 4'(d);
      ifc.read_input   = 1'b1;
      cyc();
      ifc.read_input   = 1'b0;
      cyc();
   endtask

   task automatic press_sign();
      ifc.sign_input = 1'b1;
      cyc();
      ifc.sign_input = 1'b0;
      cyc();
   endtask

   task automatic press_op(input logic [2:0] o);
      ifc.operator_input = o;
      cyc();
      ifc.operator_input = 3'b000;
      cyc();
   endtask

   task automatic do_clear();
      ifc.clear_input = 1'b1;
      cyc();
      ifc.clear_input = 1'b0;
      cyc();
   endtask

   task automatic enter_num(input int v);
      int m;
      int n;
      int digs[12];
      m = (v < 0) ? -v : v;
      n = 0;
      if (m == 0) begin
         digs[0] = 0;
         n = 1;
      end
      while (m > 0) begin
         digs[n] = m % 10;
         m = m / 10;
         n++;
      end
      for (int i = n - 1; i >= 0; i--) press_digit(digs[i]);
      if (v < 0) press_sign();
   endtask

   // Press equal and wait (bounded) for complete.
   task automatic run_equal(input string tag);
      ifc.equal_input = 1'b1;
      cyc();
      ifc.equal_input = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (ifc.complete === 1'b1) break;
         cyc();
      end
      check({tag, "_complete"}, 32'(ifc.complete), 32'd1);
   endtask

   task automatic calc(input string tag, input int a, input logic [2:0] o, input int b,
                       input logic [15:0] exp_res, input logic exp_ovf);
      do_clear();
      enter_num(a);
      press_op(o);
      enter_num(b);
      run_equal(tag);
      check({tag, "_result"}, 32'(ifc.display_output), 32'(exp_res));
      check({tag, "_ovf"}, 32'(ifc.overflow), 32'(exp_ovf));
   endtask

   initial begin
      int bad;
      ifc.keypad_input   = 4'd0;
      ifc.read_input     = 1'b0;
      ifc.sign_input     = 1'b0;
      ifc.operator_input = 3'b000;
      ifc.equal_input    = 1'b0;
      ifc.clear_input    = 1'b0;
      repeat (3) cyc();
      check("rst_complete", 32'(ifc.complete), 32'd0);
      check("rst_busy", 32'(ifc.busy), 32'd0);
      check("rst_overflow", 32'(ifc.overflow), 32'd0);
      check("rst_display", 32'(ifc.display_output), 32'd0);
      RST = 1'b0;
      cyc();

      // 1000 + 2345 with exact latency
      enter_num(1000);
      check("add_a_disp", 32'(ifc.display_output), 32'd1000);
      press_op(3'b001);
      check("add_b_shows_a", 32'(ifc.display_output), 32'd1000);
      enter_num(2345);
      check("add_b_disp", 32'(ifc.display_output), 32'd2345);
      ifc.equal_input = 1'b1;
      cyc();
      check("add_busy_k", 32'(ifc.busy), 32'd1);
      check("add_cmp_k", 32'(ifc.complete), 32'd0);
      ifc.equal_input = 1'b0;
      cyc();
      check("add_cmp_k1", 32'(ifc.complete), 32'd1);
      check("add_busy_k1", 32'(ifc.busy), 32'd0);
      check("add_result", 32'(ifc.display_output), 32'h0D11);
      check("add_ovf", 32'(ifc.overflow), 32'd0);

      calc("addneg", -25, 3'b001, -15, 16'hFFD8, 1'b0);

      // 128 * 256 with exact latency
      do_clear();
      enter_num(128);
      press_op(3'b100);
      enter_num(256);
      ifc.equal_input = 1'b1;
      cyc();
      ifc.equal_input = 1'b0;
      check("mul_busy_k", 32'(ifc.busy), 32'd1);
      bad = 0;
      for (int i = 1; i <= 16; i++) begin
         cyc();
         if (ifc.complete !== 1'b0 || ifc.busy !== 1'b1) bad++;
      end
      check("mul_wait_busy", 32'(bad), 32'd0);
      cyc();
      check("mul_cmp_k17", 32'(ifc.complete), 32'd1);
      check("mul_busy_k17", 32'(ifc.busy), 32'd0);
      check("mul_result", 32'(ifc.display_output), 32'h8000);
      check("mul_ovf", 32'(ifc.overflow), 32'd1);

      calc("mulneg", -12, 3'b100, 3000, 16'h7360, 1'b1);
      calc("mulm1", -1, 3'b100, -1, 16'h0001, 1'b0);

      // Entry rules
      do_clear();
      check("clear_disp", 32'(ifc.display_output), 32'd0);
      ifc.keypad_input = 4'd7;
      ifc.read_input   = 1'b1;
      repeat (4) cyc();
      ifc.read_input   = 1'b0;
      cyc();
      check("held_digit", 32'(ifc.display_output), 32'd7);
      do_clear();
      for (int d = 1; d <= 6; d++) press_digit(d);
      check("max_digits", 32'(ifc.display_output), 32'd12345);
      do_clear();
      press_digit(5);
      press_sign();
      check("sign_once", 32'(ifc.display_output), 32'hFFFB);
      press_sign();
      check("sign_twice", 32'(ifc.display_output), 32'd5);

      // Chaining
      calc("chain1", 2, 3'b001, 3, 16'd5, 1'b0);
      press_op(3'b010);
      press_digit(1);
      run_equal("chain2");
      check("chain2_result", 32'(ifc.display_output), 32'd4);
      press_digit(9);
      check("chain_new_disp", 32'(ifc.display_output), 32'd9);
      check("chain_new_cmp", 32'(ifc.complete), 32'd0);

      // Clear mid-multiply
      do_clear();
      enter_num(128);
      press_op(3'b100);
      enter_num(256);
      ifc.equal_input = 1'b1;
      cyc();
      ifc.equal_input = 1'b0;
      repeat (5) cyc();
      ifc.clear_input = 1'b1;
      cyc();
      ifc.clear_input = 1'b0;
      check("clr_mid_disp", 32'(ifc.display_output), 32'd0);
      check("clr_mid_busy", 32'(ifc.busy), 32'd0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (ifc.complete !== 1'b0) bad++;
         cyc();
      end
      check("clr_mid_never_cmp", 32'(bad), 32'd0);
      press_digit(4);
      check("clr_mid_entry_a", 32'(ifc.display_output), 32'd4);

      // Reset mid-multiply
      do_clear();
      enter_num(128);
      press_op(3'b100);
      enter_num(256);
      ifc.equal_input = 1'b1;
      cyc();
      ifc.equal_input = 1'b0;
      repeat (5) cyc();
      RST = 1'b1;
      #1;
      check("rst_mid_busy", 32'(ifc.busy), 32'd0);
      check("rst_mid_cmp", 32'(ifc.complete), 32'd0);
      check("rst_mid_ovf", 32'(ifc.overflow), 32'd0);
      check("rst_mid_disp", 32'(ifc.display_output), 32'd0);
      cyc();
      RST = 1'b0;
      cyc();
      enter_num(4);
      press_op(3'b100);
      enter_num(3);
      run_equal("post_rst");
      check("post_rst_result", 32'(ifc.display_output), 32'd12);

      // Boundaries
      calc("minmax", -32768, 3'b001, 32767, 16'hFFFF, 1'b0);
      calc("addovf", 32767, 3'b001, 1, 16'h8000, 1'b1);
      calc("subneg", 0, 3'b010, 99, 16'hFF9D, 1'b0);
      do_clear();
      press_digit(5);
      press_op(3'b011);
      press_digit(6);
      check("bad_op_ignored", 32'(ifc.display_output), 32'd56);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end
endmodule
